// File: rtl/mem_pipe_pkg.sv
// Shared widths, opcode ranges, write masks and stage-register layouts for the
// memory pipeline (MEM_A -> MEM_B -> WB).
package mem_pipe_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int OPC_W  = 5;

  // Load opcode ranges: word, double (16-bit), byte
  localparam logic [OPC_W-1:0] MEM_W_LO = 5'd3;
  localparam logic [OPC_W-1:0] MEM_W_HI = 5'd5;
  localparam logic [OPC_W-1:0] MEM_D_LO = 5'd6;
  localparam logic [OPC_W-1:0] MEM_D_HI = 5'd8;
  localparam logic [OPC_W-1:0] MEM_B_LO = 5'd9;
  localparam logic [OPC_W-1:0] MEM_B_HI = 5'd11;

  localparam logic [3:0] WE_W = 4'b1111;
  localparam logic [3:0] WE_D = 4'b0011;
  localparam logic [3:0] WE_B = 4'b0001;

  typedef struct packed {
    logic              bubble;
    logic              is_load;
    logic              halt;
    logic [OPC_W-1:0]  opcode;
    logic [1:0]        addr_lo;
    logic [REG_W-1:0]  tgt_1;
    logic [REG_W-1:0]  tgt_2;
    logic [DATA_W-1:0] res_1;
    logic [DATA_W-1:0] res_2;
  } mb_t;

  typedef struct packed {
    logic              bubble;
    logic              halt;
    logic [REG_W-1:0]  tgt_1;
    logic [REG_W-1:0]  tgt_2;
    logic [DATA_W-1:0] res_1;
    logic [DATA_W-1:0] res_2;
  } wb_t;

  localparam mb_t MB_RST = '{bubble: 1'b1, default: '0};
  localparam wb_t WB_RST = '{bubble: 1'b1, default: '0};

  function automatic logic in_range(input logic [OPC_W-1:0] op,
                                    input logic [OPC_W-1:0] lo,
                                    input logic [OPC_W-1:0] hi);
    return (op >= lo) && (op <= hi);
  endfunction

  // Byte offset for store alignment: words never shift, doubles snap to a
  // 2-byte boundary, bytes use the full low address.
  function automatic logic [1:0] store_shift(input logic [3:0] we, input logic [1:0] a);
    case (we)
      WE_W:    return 2'b00;
      WE_D:    return {a[1], 1'b0};
      WE_B:    return a;
      default: return a;
    endcase
  endfunction

endpackage

// File: rtl/mem_pipe_if.sv
// Data-memory port: request from the pipeline, read data back one cycle later.
interface mem_pipe_if
  import mem_pipe_pkg::*;
#(parameter int ADDR_W = 32);

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic [3:0]        mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_addr, mem_re, mem_we, mem_wdata, input mem_rdata);
  modport slave  (input mem_addr, mem_re, mem_we, mem_wdata, output mem_rdata);

endinterface

// File: rtl/mem_pipe_load_align.sv
// Little-endian load extraction: selects the word, half or byte lane named by
// the opcode range and low address bits, zero-extended.
module mem_pipe_load_align
  import mem_pipe_pkg::*;
(
  input  logic [OPC_W-1:0]  opcode,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = rdata;
    if (in_range(opcode, MEM_W_LO, MEM_W_HI))
      data = rdata;
    else if (in_range(opcode, MEM_D_LO, MEM_D_HI))
      data = {16'h0000, addr_lo[1] ? rdata[31:16] : rdata[15:0]};
    else if (in_range(opcode, MEM_B_LO, MEM_B_HI))
      data = {24'h000000, rdata[{addr_lo, 3'b000} +: 8]};
  end

endmodule

// File: rtl/mem_pipe.sv
// Memory pipeline: drives the data-memory port from MEM_A, carries each
// instruction through MEM_B and WB, and formats load data on its way to WB.
module mem_pipe
  import mem_pipe_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              bubble_in,
  input  logic [OPC_W-1:0]  opcode_in,
  input  logic [REG_W-1:0]  tgt_in_1,
  input  logic [REG_W-1:0]  tgt_in_2,
  input  logic [DATA_W-1:0] result_in_1,
  input  logic [DATA_W-1:0] result_in_2,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [3:0]        we_in,
  input  logic              is_load_in,
  input  logic              is_store_in,
  input  logic              halt_in,
  mem_pipe_if.master        mem,
  output logic [REG_W-1:0]  mem_b_tgt_1,
  output logic [REG_W-1:0]  mem_b_tgt_2,
  output logic [DATA_W-1:0] mem_b_result_out_1,
  output logic [DATA_W-1:0] mem_b_result_out_2,
  output logic              mem_b_bubble,
  output logic              mem_b_is_load,
  output logic [REG_W-1:0]  wb_tgt_1,
  output logic [REG_W-1:0]  wb_tgt_2,
  output logic [DATA_W-1:0] wb_result_out_1,
  output logic [DATA_W-1:0] wb_result_out_2,
  output logic              wb_bubble,
  output logic              halt_out
);

  mb_t               mb;
  wb_t               wb;
  logic              req_ok;
  logic [1:0]        st_off;
  logic [RD_LAT-1:0] rd_pipe;
  logic [DATA_W-1:0] hold_q;
  logic              hold_vld;
  logic [DATA_W-1:0] rd_src;
  logic [DATA_W-1:0] ld_data;
  logic              unused_is_store;

  // The write mask already encodes store-ness; the flag is informational here.
  assign unused_is_store = is_store_in;

  assign req_ok         = !bubble_in && !halt && !rst;
  assign st_off         = store_shift(we_in, addr_in[1:0]);
  assign mem.mem_addr   = {addr_in[ADDR_W-1:2], 2'b00};
  assign mem.mem_re     = is_load_in && req_ok;
  assign mem.mem_we     = req_ok ? (we_in << st_off) : 4'b0000;
  assign mem.mem_wdata  = store_data_in << {st_off, 3'b000};

  // rdata arrives RD_LAT cycles after the strobe regardless of halt, so it is
  // parked in hold_q if the pipeline is frozen when it shows up.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pipe  <= '0;
      hold_q   <= '0;
      hold_vld <= 1'b0;
    end else begin
      rd_pipe[0] <= mem.mem_re;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      if (halt) begin
        if (rd_pipe[RD_LAT-1]) begin
          hold_q   <= mem.mem_rdata;
          hold_vld <= 1'b1;
        end
      end else begin
        hold_vld <= 1'b0;
      end
    end
  end

  assign rd_src = hold_vld ? hold_q : mem.mem_rdata;

  mem_pipe_load_align u_align (
    .opcode  (mb.opcode),
    .addr_lo (mb.addr_lo),
    .rdata   (rd_src),
    .data    (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mb <= MB_RST;
      wb <= WB_RST;
    end else if (!halt) begin
      mb <= '{bubble:  bubble_in,
              is_load: is_load_in,
              halt:    halt_in,
              opcode:  opcode_in,
              addr_lo: addr_in[1:0],
              tgt_1:   tgt_in_1,
              tgt_2:   tgt_in_2,
              res_1:   result_in_1,
              res_2:   result_in_2};
      wb <= '{bubble: mb.bubble,
              halt:   mb.halt && !mb.bubble,
              tgt_1:  mb.tgt_1,
              tgt_2:  mb.tgt_2,
              res_1:  (!mb.bubble && mb.is_load) ? ld_data : mb.res_1,
              res_2:  mb.res_2};
    end
  end

  assign mem_b_tgt_1        = mb.tgt_1;
  assign mem_b_tgt_2        = mb.tgt_2;
  assign mem_b_result_out_1 = mb.res_1;
  assign mem_b_result_out_2 = mb.res_2;
  assign mem_b_bubble       = mb.bubble;
  assign mem_b_is_load      = mb.is_load;
  assign wb_tgt_1           = wb.tgt_1;
  assign wb_tgt_2           = wb.tgt_2;
  assign wb_result_out_1    = wb.res_1;
  assign wb_result_out_2    = wb.res_2;
  assign wb_bubble          = wb.bubble;
  assign halt_out           = wb.halt;

endmodule

// File: tb/tb_mem_pipe.sv
// Randomized bench for mem_pipe: a two-deep history of issued instructions
// predicts MEM_B/WB, and a word array stands in for data memory.
module tb_mem_pipe;

  logic        clk = 1'b0;
  logic        rst, halt, bubble_in;
  logic [4:0]  opcode_in, tgt_in_1, tgt_in_2;
  logic [31:0] result_in_1, result_in_2, addr_in, store_data_in;
  logic [3:0]  we_in;
  logic        is_load_in, is_store_in, halt_in;
  logic [4:0]  mem_b_tgt_1, mem_b_tgt_2, wb_tgt_1, wb_tgt_2;
  logic [31:0] mem_b_result_out_1, mem_b_result_out_2, wb_result_out_1, wb_result_out_2;
  logic        mem_b_bubble, mem_b_is_load, wb_bubble, halt_out;

  always #5 clk = ~clk;

  mem_pipe_if mif ();

  mem_pipe dut (
    .clk(clk), .rst(rst), .halt(halt), .bubble_in(bubble_in), .opcode_in(opcode_in),
    .tgt_in_1(tgt_in_1), .tgt_in_2(tgt_in_2),
    .result_in_1(result_in_1), .result_in_2(result_in_2),
    .addr_in(addr_in), .store_data_in(store_data_in), .we_in(we_in),
    .is_load_in(is_load_in), .is_store_in(is_store_in), .halt_in(halt_in),
    .mem(mif),
    .mem_b_tgt_1(mem_b_tgt_1), .mem_b_tgt_2(mem_b_tgt_2),
    .mem_b_result_out_1(mem_b_result_out_1), .mem_b_result_out_2(mem_b_result_out_2),
    .mem_b_bubble(mem_b_bubble), .mem_b_is_load(mem_b_is_load),
    .wb_tgt_1(wb_tgt_1), .wb_tgt_2(wb_tgt_2),
    .wb_result_out_1(wb_result_out_1), .wb_result_out_2(wb_result_out_2),
    .wb_bubble(wb_bubble), .halt_out(halt_out)
  );

  typedef struct {
    bit        bubble, is_load, is_store, hlt;
    bit [4:0]  op, t1, t2;
    bit [31:0] r1, r2, addr, sd;
    bit [3:0]  we;
  } ins_t;

  logic [31:0] mem_arr [256];
  ins_t        hist[$];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ins_t bub_ins();
    ins_t i;
    i = '{default: '0};
    i.bubble = 1'b1;
    return i;
  endfunction

  // Little-endian lane pick from a whole memory word, by opcode class.
  function automatic logic [31:0] fmt(input logic [31:0] rd, input int op, input int a);
    if (op >= 9 && op <= 11) return (rd >> (8 * a)) & 32'hFF;
    if (op >= 6 && op <= 8)  return (a >= 2) ? (rd >> 16) : (rd & 32'hFFFF);
    return rd;
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    int   kind, sz;
    i = '{default: '0};
    kind = $urandom_range(0, 2);
    i.bubble = ($urandom_range(0, 4) == 0);
    i.hlt = ($urandom_range(0, 15) == 0);
    i.t1 = 5'($urandom); i.t2 = 5'($urandom);
    i.r1 = $urandom;     i.r2 = $urandom;
    i.addr = $urandom;   i.sd = $urandom;
    if (kind == 0) begin
      i.is_load = 1'b1;
      i.op = 5'($urandom_range(3, 11));
    end else if (kind == 1) begin
      i.is_store = 1'b1;
      i.op = 5'($urandom_range(12, 20));
      sz = $urandom_range(0, 2);
      i.we = (sz == 0) ? 4'hF : (sz == 1) ? 4'h3 : 4'h1;
    end else begin
      i.op = 5'($urandom_range(0, 2));
    end
    return i;
  endfunction

  task automatic drive(input ins_t i, input bit h, input bit r);
    bubble_in = i.bubble; opcode_in = i.op; tgt_in_1 = i.t1; tgt_in_2 = i.t2;
    result_in_1 = i.r1; result_in_2 = i.r2; addr_in = i.addr; store_data_in = i.sd;
    we_in = i.we; is_load_in = i.is_load; is_store_in = i.is_store; halt_in = i.hlt;
    halt = h; rst = r;
    #1;
  endtask

  task automatic step(input ins_t i, input bit h, input bit r);
    int          off;
    int          wexp;
    bit          re_now;
    logic [31:0] a_now;
    ins_t        m, w;
    logic [31:0] wres;
    drive(i, h, r);
    off  = (i.we == 4'hF) ? 0 : (i.we == 4'h3) ? 2 * int'(i.addr[1]) : int'(i.addr[1:0]);
    wexp = (i.bubble || h || r) ? 0 : ((int'(i.we) << off) & 15);
    chk("mem_addr",  mif.mem_addr, i.addr & 32'hFFFF_FFFC);
    chk("mem_re",    32'(mif.mem_re), 32'(i.is_load && !i.bubble && !h && !r));
    chk("mem_we",    32'(mif.mem_we), wexp);
    chk("mem_wdata", mif.mem_wdata, i.sd << (8 * off));
    re_now = mif.mem_re;
    a_now  = mif.mem_addr;
    @(posedge clk);
    if (r) begin
      hist.delete();
      hist.push_back(bub_ins());
      hist.push_back(bub_ins());
    end else if (!h) begin
      hist.push_back(i);
      void'(hist.pop_front());
    end
    #1;
    mif.mem_rdata = re_now ? mem_arr[a_now[9:2]] : $urandom;
    m = hist[1];
    w = hist[0];
    wres = (!w.bubble && w.is_load) ? fmt(mem_arr[w.addr[9:2]], w.op, w.addr[1:0]) : w.r1;
    chk("mb_tgt1",   32'(mem_b_tgt_1), 32'(m.t1));
    chk("mb_tgt2",   32'(mem_b_tgt_2), 32'(m.t2));
    chk("mb_res1",   mem_b_result_out_1, m.r1);
    chk("mb_res2",   mem_b_result_out_2, m.r2);
    chk("mb_bubble", 32'(mem_b_bubble), 32'(m.bubble));
    chk("mb_isload", 32'(mem_b_is_load), 32'(m.is_load));
    chk("wb_tgt1",   32'(wb_tgt_1), 32'(w.t1));
    chk("wb_tgt2",   32'(wb_tgt_2), 32'(w.t2));
    chk("wb_res1",   wb_result_out_1, wres);
    chk("wb_res2",   wb_result_out_2, w.r2);
    chk("wb_bubble", 32'(wb_bubble), 32'(w.bubble));
    chk("halt_out",  32'(halt_out), 32'(w.hlt && !w.bubble));
  endtask

  initial begin
    ins_t i;
    for (int k = 0; k < 256; k++) mem_arr[k] = $urandom;
    mem_arr[8'h40] = 32'h11223344;
    mem_arr[8'h80] = 32'hCAFEBEEF;
    mem_arr[8'hC0] = 32'h5A5AC3C3;
    mif.mem_rdata = '0;

    step(bub_ins(), 1'b0, 1'b1);
    step(bub_ins(), 1'b1, 1'b1);
    chk("rst_wb_bubble", 32'(wb_bubble), 32'd1);
    chk("rst_mb_tgt1",   32'(mem_b_tgt_1), 32'd0);

    // Word store at 0x104
    i = bub_ins(); i.bubble = 0; i.is_store = 1; i.op = 5'd12;
    i.addr = 32'h104; i.sd = 32'hDEADBEEF; i.we = 4'hF;
    drive(i, 1'b0, 1'b0);
    chk("stw_addr",  mif.mem_addr, 32'h104);
    chk("stw_we",    32'(mif.mem_we), 32'hF);
    chk("stw_wdata", mif.mem_wdata, 32'hDEADBEEF);
    step(i, 1'b0, 1'b0);

    // Byte store at 0x103
    i.addr = 32'h103; i.sd = 32'h000000AB; i.we = 4'h1;
    drive(i, 1'b0, 1'b0);
    chk("stb_we",    32'(mif.mem_we), 32'h8);
    chk("stb_wdata", mif.mem_wdata, 32'hAB000000);
    step(i, 1'b0, 1'b0);

    // Byte load, op 9, addr 0x102: data two posedges later
    i = bub_ins(); i.bubble = 0; i.is_load = 1; i.op = 5'd9; i.addr = 32'h102; i.t1 = 5'd5;
    step(i, 1'b0, 1'b0);
    step(bub_ins(), 1'b0, 1'b0);
    chk("ldb_tgt", 32'(wb_tgt_1), 32'd5);
    chk("ldb_res", wb_result_out_1, 32'h00000022);

    // Double load, op 6, addr 0x203: addr[0] ignored
    i.op = 5'd6; i.addr = 32'h203; i.t1 = 5'd7;
    step(i, 1'b0, 1'b0);
    step(bub_ins(), 1'b0, 1'b0);
    chk("ldd_res", wb_result_out_1, 32'h0000CAFE);

    // Halt rises the cycle rdata is valid, held 3 cycles
    i.op = 5'd4; i.addr = 32'h300; i.t1 = 5'd9;
    step(i, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(bub_ins(), 1'b1, 1'b0);
    step(bub_ins(), 1'b0, 1'b0);
    chk("hold_tgt", 32'(wb_tgt_1), 32'd9);
    chk("hold_res", wb_result_out_1, 32'h5A5AC3C3);

    // Reset pulsed while a load is in MEM_B
    step(i, 1'b0, 1'b0);
    i = bub_ins(); i.bubble = 0; i.is_store = 1; i.we = 4'hF; i.addr = 32'h10;
    drive(i, 1'b0, 1'b1);
    chk("rst_we", 32'(mif.mem_we), 32'd0);
    step(i, 1'b0, 1'b1);
    chk("rst_mb_bub", 32'(mem_b_bubble), 32'd1);
    step(bub_ins(), 1'b0, 1'b0);
    chk("rst_no_wb", 32'(wb_bubble), 32'd1);

    for (int n = 0; n < 3000; n++)
      step(rand_ins(), ($urandom_range(0, 4) == 0), ($urandom_range(0, 49) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
